// File: rtl/fetch_pc_unit_pkg.sv
// pipeline_defs: shared fetch-stage encodings and constants.
package pipeline_defs;
  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fetch_state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory req/ack bus.
interface fetch_pc_unit_if;
  logic imem_req;
  logic imem_ack;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_pc_unit_branch_target_calc.sv
// branch_target_calc: pc4 plus sign-extended word offset, wrapping modulo 2^32.
module branch_target_calc (
  input  logic [31:0] pc4,
  input  logic [15:0] off16,
  output logic [31:0] target
);
  assign target = pc4 + {{14{off16[15]}}, off16, 2'b00};
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC, imem req/ack fetch, delay-slot branch redirect and one-word skid into IF/ID.
module fetch_pc_unit
  import pipeline_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fetch_pc_unit_if.master        imem,
  input  logic                   stall_id,
  input  logic                   branch_valid,
  input  logic                   branch_imm,
  input  logic [15:0]            branch_off16,
  input  logic [31:0]            pc4_id,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc4
);
  fetch_state_t state, state_nxt;
  logic [31:0] pc_q, redir_q, skid_instr, skid_pc4, target, pc_inc, next_addr;
  logic redir_pend, take, ack, hold;

  branch_target_calc u_btc (.pc4(pc4_id), .off16(branch_off16), .target(target));

  assign hold = state == HOLD;
  assign take = branch_valid && branch_imm && !stall_id;
  assign ack = imem.imem_ack && !hold;
  assign pc_inc = pc_q + WORD_BYTES;
  assign next_addr = take ? target : redir_pend ? redir_q : pc_inc;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FETCH;
    else state <= state_nxt;

  always_comb state_nxt = hold ? (stall_id ? HOLD : FETCH) : (ack && stall_id ? HOLD : FETCH);

  always_comb begin
    imem.imem_req = reset_n && !hold;
    imem.imem_addr = pc_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc_q <= RESET_PC;
      redir_q <= '0;
      redir_pend <= 1'b0;
      skid_instr <= '0;
      skid_pc4 <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc4 <= '0;
    end else begin
      // an un-acked take leaves the in-flight fetch as the delay slot
      if (ack) begin
        pc_q <= next_addr;
        redir_pend <= 1'b0;
      end else if (take && !hold) begin
        redir_q <= target;
        redir_pend <= 1'b1;
      end else if (take) pc_q <= target;
      if (ack && stall_id) begin
        skid_instr <= imem.imem_rdata;
        skid_pc4 <= pc_inc;
      end
      if (!stall_id) begin
        if_valid <= hold || ack;
        if (hold) begin
          if_instr <= skid_instr;
          if_pc4 <= skid_pc4;
        end else if (ack) begin
          if_instr <= imem.imem_rdata;
          if_pc4 <= pc_inc;
        end
      end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven and hand-sequenced checks with an issue scoreboard.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stall_id = 1'b0, branch_valid = 1'b0, branch_imm = 1'b0;
  logic [15:0] branch_off16 = '0;
  logic [31:0] pc4_id = '0;
  logic if_valid;
  logic [31:0] if_instr, if_pc4;
  int checks = 0, errors = 0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .clk(clk), .reset_n(reset_n), .imem(bus), .stall_id(stall_id),
    .branch_valid(branch_valid), .branch_imm(branch_imm), .branch_off16(branch_off16),
    .pc4_id(pc4_id), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;
  typedef struct {
    bit ack; bit st; bit bv; bit bi;
    logic [15:0] off; logic [31:0] p4;
    bit ereq; logic [31:0] eaddr;
  } vec_t;

  exp_t q[$];
  exp_t last;
  bit lastv = 0;
  vec_t tbl[13];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: drive, check bus before the edge, check IF/ID after it
  task automatic cyc(input bit ack, input bit st, input bit bv, input bit bi,
                     input logic [15:0] off, input logic [31:0] p4,
                     input bit ereq, input logic [31:0] eaddr);
    exp_t e;
    bus.imem_ack = ack;
    bus.imem_rdata = ack ? mem(eaddr) : 32'h0;
    stall_id = st; branch_valid = bv; branch_imm = bi; branch_off16 = off; pc4_id = p4;
    @(negedge clk);
    chk("imem_req", {31'h0, bus.imem_req}, {31'h0, ereq});
    if (ereq) chk("imem_addr", bus.imem_addr, eaddr);
    if (ack && ereq) q.push_back('{mem(eaddr), eaddr + 32'd4});
    @(posedge clk); #1;
    if (!st) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("if_valid", {31'h0, if_valid}, 32'd1);
        chk("if_instr", if_instr, e.instr);
        chk("if_pc4", if_pc4, e.pc4);
        last = e; lastv = 1;
      end else begin
        chk("if_valid_bubble", {31'h0, if_valid}, 32'd0);
        lastv = 0;
      end
    end else begin
      chk("if_valid_held", {31'h0, if_valid}, {31'h0, lastv});
      if (lastv) begin
        chk("if_instr_held", if_instr, last.instr);
        chk("if_pc4_held", if_pc4, last.pc4);
      end
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_req"}, {31'h0, bus.imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'd0);
    chk({tag, "_instr"}, if_instr, 32'd0);
    chk({tag, "_pc4"}, if_pc4, 32'd0);
  endtask

  task automatic mid_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 reset_outputs(tag);
    q.delete();
    lastv = 0;
    bus.imem_ack = 1'b0; stall_id = 1'b0; branch_valid = 1'b0; branch_imm = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 32'h0,         1, 32'h0000_0000};
    tbl[1]  = '{1, 0, 0, 0, 16'h0000, 32'h0,         1, 32'h0000_0004};
    tbl[2]  = '{1, 0, 0, 0, 16'h0000, 32'h0,         1, 32'h0000_0008};
    tbl[3]  = '{1, 0, 0, 0, 16'h0000, 32'h0,         1, 32'h0000_000C};
    tbl[4]  = '{1, 0, 1, 1, 16'h0004, 32'h10,        1, 32'h0000_0010};
    tbl[5]  = '{1, 0, 1, 1, 16'hFFFC, 32'h10,        1, 32'h0000_0020};
    tbl[6]  = '{1, 0, 1, 0, 16'h0040, 32'h10,        1, 32'h0000_0000};
    tbl[7]  = '{1, 0, 0, 0, 16'h0000, 32'h0,         1, 32'h0000_0004};
    tbl[8]  = '{1, 0, 0, 1, 16'h0040, 32'h10,        1, 32'h0000_0008};
    tbl[9]  = '{1, 0, 1, 1, 16'h0003, 32'hFFFF_FFF0, 1, 32'h0000_000C};
    tbl[10] = '{1, 0, 0, 0, 16'h0000, 32'h0,         1, 32'hFFFF_FFFC};
    tbl[11] = '{1, 0, 0, 0, 16'h0000, 32'h0,         1, 32'h0000_0000};
    tbl[12] = '{0, 0, 0, 0, 16'h0000, 32'h0,         1, 32'h0000_0004};

    #3 reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      cyc(tbl[i].ack, tbl[i].st, tbl[i].bv, tbl[i].bi, tbl[i].off, tbl[i].p4, tbl[i].ereq, tbl[i].eaddr);

    // ack withheld while a take happens: delay slot completes, then target
    cyc(0, 0, 1, 1, 16'h0010, 32'h100, 1, 32'h4);
    cyc(0, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h4);
    cyc(0, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h4);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h4);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h140);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h144);

    // stall for 4 cycles over an acked fetch; stray ack while req low is ignored
    cyc(1, 1, 0, 0, 16'h0000, 32'h0,   1, 32'h148);
    cyc(1, 1, 0, 0, 16'h0000, 32'h0,   0, 32'h0);
    cyc(0, 1, 0, 0, 16'h0000, 32'h0,   0, 32'h0);
    cyc(0, 1, 0, 0, 16'h0000, 32'h0,   0, 32'h0);
    cyc(0, 0, 0, 0, 16'h0000, 32'h0,   0, 32'h0);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h14C);

    // stall again, stalled take ignored, take lands in the release cycle
    cyc(1, 1, 0, 0, 16'h0000, 32'h0,   1, 32'h150);
    cyc(0, 1, 1, 1, 16'h0001, 32'h999, 0, 32'h0);
    cyc(0, 1, 0, 0, 16'h0000, 32'h0,   0, 32'h0);
    cyc(0, 0, 1, 1, 16'hFFF0, 32'h200, 0, 32'h0);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h1C0);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h1C4);

    // reset with a redirect pending: restart at RESET_PC, no redirect
    cyc(0, 0, 1, 1, 16'h0040, 32'h300, 1, 32'h1C8);
    mid_reset("rst_redir");
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h0);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h4);

    // reset mid-HOLD: buffered word is dropped
    cyc(1, 1, 0, 0, 16'h0000, 32'h0,   1, 32'h8);
    cyc(0, 1, 0, 0, 16'h0000, 32'h0,   0, 32'h0);
    mid_reset("rst_hold");
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h0);
    cyc(1, 0, 0, 0, 16'h0000, 32'h0,   1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the 5-stage pipeline. Holds the program counter, requests instructions from instruction memory with a req/ack handshake, and fills the IF/ID pipeline register. It is the direct consumer of the ID-stage branch decision: it takes the taken/not-taken flag and the branch immediate, and redirects fetch after the architectural delay slot. It buffers one fetched word when ID stalls.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
- stall_id  in  1  hazard unit holds IF/ID; no IF/ID update while high.
- branch_valid  in  1  ID holds a BEQ or BNE this cycle.
- branch_imm  in  1  branch taken flag from ID equality check; ignored unless branch_valid.
- branch_off16  in  16  raw branch immediate of the instruction in ID.
- pc4_id  in  32  PC+4 of the instruction in ID, i.e. the delay-slot address.
- imem_req  out  1  fetch request; held high with imem_addr stable until imem_ack.
- imem_addr  out  32  fetch address, always pc_q during a request.
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req low.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- if_instr  out  32  IF/ID instruction.
- if_pc4  out  32  IF/ID PC+4.

## Operation
- Registers: pc_q, state, skid buffer (instr + pc4), redir_q[31:0], redir_pend, IF/ID outputs.
- Branch target = pc4_id + (sign_extend(branch_off16) << 2), modulo 2^32.
- Branch capture, "take": branch_valid && branch_imm && !stall_id.
- The state machine has two states.
  - FETCH:
    - imem_req=1.
    - On ack with !stall_id: load IF/ID (valid=1, instr=rdata, pc4=pc_q+4).
    - On ack with stall_id: load the skid buffer and go to HOLD.
    - On any ack: pc_q <= next address.
    - No ack with !stall_id: if_valid <= 0 (bubble).
  - HOLD:
    - imem_req=0.
    - When !stall_id: load IF/ID from the skid buffer (valid=1) and go to FETCH.
- Next address on ack, by priority:
  - take this cycle: target.
  - else redir_pend: redir_q; clear redir_pend.
  - else pc_q+4.
- Redirect while not in an acked FETCH cycle:
  - take in FETCH without ack: redir_q <= target, redir_pend <= 1. The in-flight fetch is the delay slot and completes normally.
  - take in HOLD: the delay slot is already buffered, so pc_q <= target directly.
- While stall_id is high, IF/ID outputs hold their values, including if_valid.
- PC arithmetic is 32-bit and wraps modulo 2^32. No alignment check.

## Timing
- Reset (asynchronous, immediate):
  - state=FETCH, pc_q=RESET_PC.
  - if_valid=0, if_instr=0, if_pc4=0.
  - redir_pend=0, redir_q=0, skid buffer=0.
  - imem_req goes to 0 while reset_n is low, and to 1 in the first cycle after release.
- imem_req/imem_addr are combinational from state/pc_q. No glitch on addr while req is high.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. The IF/ID update is visible the cycle after ack.
- Taken branch: the delay slot is fetched and issued. The target is the first fetch after the delay-slot ack. Target+0 appears in IF/ID two cycles after the branch leaves ID (zero-wait case).
- take and ack in the same cycle: the target is used directly and redir_pend stays 0.
- Reset during HOLD or with redir_pend set: buffered word and pending redirect are discarded.

## Structure
- Shared package pipeline_defs holds:
  - fetch state encoding (FETCH=0, HOLD=1).
  - WORD_BYTES=4.
  - default RESET_PC.
- One sub-module, branch_target_calc: combinational sign-extend, shift and add of pc4_id and branch_off16. It is reused by any later ID-stage jump logic.

## Test plan
- Reset release, RESET_PC=0, ack every cycle: imem_addr sequence 0,4,8,C; if_pc4 sequence 4,8,C,10; if_valid high from cycle 2.
- Branch taken: pc4_id=0x10, off16=0x0004, taken in ID. Delay slot at 0x10 issues; next imem_addr=0x20. Repeat with off16=0xFFFC → 0x00.
- Not-taken: branch_valid=1, branch_imm=0 → addresses continue sequentially.
- Ack withheld: ack delayed 3 cycles while a take occurs. redir_pend=1 during the wait, delay-slot word issues, next fetch address = target, redir_pend cleared.
- stall_id high for 4 cycles during an acked fetch:
  - State goes to HOLD, req low, IF/ID unchanged.
  - On release, the buffered word is issued and FETCH resumes at the next address with no duplicate or loss.
  - Repeat with the take arriving in the release cycle.
- Reset asserted mid-HOLD with redir_pend set:
  - Outputs go to reset values immediately.
  - Fetch restarts at RESET_PC with no redirect applied.
